// File: rtl/mult_arbiter.sv
// Four requesters share one combinational multiplier through a round-robin grant.
// Two-cycle latency (operand register, product register); no response backpressure.

module multiplier #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic [OUT_W-1:0] o_prod
);
  // Multiplying at OUT_W width gives the low bits of the full product,
  // or the zero-extended exact product when OUT_W exceeds 2*IN_W.
  assign o_prod = OUT_W'(i_a) * OUT_W'(i_b);
endmodule

module mult_arbiter #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_valid,
  input  logic [4*IN_W-1:0] req_data0,
  input  logic [4*IN_W-1:0] req_data1,
  output logic [3:0]        req_ready,
  output logic [3:0]        resp_valid,
  output logic [OUT_W-1:0]  resp_prod,
  output logic              busy
);

  logic [1:0]       r_ptr;
  logic             r_s1_vld;
  logic [1:0]       r_s1_id;
  logic [IN_W-1:0]  r_s1_a;
  logic [IN_W-1:0]  r_s1_b;
  logic [3:0]       r_resp_vld;
  logic [OUT_W-1:0] r_resp_prod;

  logic             w_found;
  logic [1:0]       w_gnt_id;
  logic [1:0]       w_idx;
  logic             w_xfer;
  logic [OUT_W-1:0] w_prod;

  // Scan from the pointer upward; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = 2'd0;
    w_idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  assign w_xfer = w_found && !rst;

  always_comb begin
    req_ready = 4'b0000;
    if (w_xfer) req_ready[w_gnt_id] = 1'b1;
  end

  multiplier #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_mult (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_prod (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 2'd0;
      r_s1_vld    <= 1'b0;
      r_s1_id     <= 2'd0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_resp_vld  <= 4'b0000;
      r_resp_prod <= '0;
    end else begin
      r_s1_vld <= w_xfer;
      if (w_xfer) begin
        r_ptr   <= w_gnt_id + 2'd1;
        r_s1_id <= w_gnt_id;
        r_s1_a  <= req_data0[w_gnt_id*IN_W +: IN_W];
        r_s1_b  <= req_data1[w_gnt_id*IN_W +: IN_W];
      end
      r_resp_vld <= r_s1_vld ? (4'b0001 << r_s1_id) : 4'b0000;
      // Product is only captured alongside a strobe so it holds between results.
      if (r_s1_vld) r_resp_prod <= w_prod;
    end
  end

  assign resp_valid = r_resp_vld;
  assign resp_prod  = r_resp_prod;
  assign busy       = r_s1_vld | (|r_resp_vld);

endmodule
